serial_arith_nch: RTL and testbench

Multi-channel, word-framed serial arithmetic unit for LSB-first bit streams. It extends the single-channel serial two's-complementer to:
- NCH parallel lanes sharing one framing counter;
- a per-word operation mode (pass, negate, increment, decrement);
- valid-qualified input with stall support;
- automatic state restart at word boundaries;
- a per-lane signed-overflow flag.

It sits between serial deserialiser front-ends and downstream bit-serial datapaths.

---
 rtl/serial_arith_nch_if.sv | 24 ++
 rtl/serial_arith_nch.sv | 105 ++++++++++
 tb/tb_serial_arith_nch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/serial_arith_nch_if.sv
// Bit-lane bus between a deserialiser front-end and serial_arith_nch.
// The master drives bits and per-word controls; the slave returns results.
interface serial_arith_nch_if #(
    parameter int NCH = 4
);
    logic           sclr;
    logic [1:0]     mode;
    logic           in_valid;
    logic [NCH-1:0] x;
    logic [NCH-1:0] z;
    logic           z_valid;
    logic           z_last;
    logic [NCH-1:0] ovf;

    modport master (
        output sclr, mode, in_valid, x,
        input  z, z_valid, z_last, ovf
    );

    modport slave (
        input  sclr, mode, in_valid, x,
        output z, z_valid, z_last, ovf
    );
endinterface

// File: rtl/serial_arith_nch.sv
// NCH-lane LSB-first serial arithmetic unit: pass, negate, +1 or -1 per word,
// with one shared bit counter and a per-lane signed-overflow flag.
module serial_arith_nch #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               areset,
    serial_arith_nch_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_NEG  = 2'd1,
        MODE_INC  = 2'd2,
        MODE_DEC  = 2'd3
    } mode_e;

    logic [CW-1:0]  bitcnt;
    mode_e          mode_q;
    logic [NCH-1:0] c;
    logic [NCH-1:0] ovf_q;

    logic           first_bit;
    logic           last_bit;
    mode_e          eff_mode;
    logic [NCH-1:0] c_eff;
    logic [NCH-1:0] c_next;
    logic [NCH-1:0] z_int;
    logic [NCH-1:0] ovf_cond;

    assign first_bit = (bitcnt == '0);
    assign last_bit  = (bitcnt == CW'(WIDTH - 1));
    assign eff_mode  = first_bit ? mode_e'(bus.mode) : mode_q;

    // Bit 0 ignores the stored carry/borrow so words can run back to back.
    always_comb begin
        c_eff = c;
        if (first_bit) begin
            case (eff_mode)
                MODE_NEG: c_eff = '0;
                MODE_INC: c_eff = '1;
                MODE_DEC: c_eff = '1;
                default:  c_eff = '0;
            endcase
        end
    end

    always_comb begin
        z_int    = bus.x;
        c_next   = c_eff;
        ovf_cond = '0;
        case (eff_mode)
            MODE_NEG: begin
                z_int    = bus.x ^ c_eff;
                c_next   = c_eff | bus.x;
                ovf_cond = ~c_eff & bus.x;
            end
            MODE_INC: begin
                z_int    = bus.x ^ c_eff;
                c_next   = c_eff & bus.x;
                ovf_cond = c_eff & ~bus.x;
            end
            MODE_DEC: begin
                z_int    = bus.x ^ c_eff;
                c_next   = c_eff & ~bus.x;
                ovf_cond = c_eff & bus.x;
            end
            default: begin
                z_int    = bus.x;
                c_next   = c_eff;
                ovf_cond = '0;
            end
        endcase
    end

    // sclr wins over a simultaneous valid bit: the bit shows on z but nothing advances.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            bitcnt <= '0;
            mode_q <= MODE_PASS;
            c      <= '0;
            ovf_q  <= '0;
        end else if (bus.sclr) begin
            bitcnt <= '0;
            c      <= '0;
            ovf_q  <= '0;
        end else begin
            ovf_q <= (bus.in_valid && last_bit) ? ovf_cond : '0;
            if (bus.in_valid) begin
                bitcnt <= last_bit ? '0 : bitcnt + CW'(1);
                c      <= c_next;
                if (first_bit) begin
                    mode_q <= mode_e'(bus.mode);
                end
            end
        end
    end

    assign bus.z       = z_int;
    assign bus.z_valid = bus.in_valid;
    assign bus.z_last  = bus.in_valid && last_bit;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_serial_arith_nch.sv
// Scoreboard bench for serial_arith_nch: the driver queues hand-computed
// results, a negedge monitor pops and compares them as the DUT presents them.
module tb_serial_arith_nch;
    localparam int NCH   = 4;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [NCH-1:0] z;
        logic           last;
    } zexp_t;

    logic clk;
    logic areset;
    int   errors;
    int   checks;

    zexp_t          z_q[$];
    logic [NCH-1:0] ovf_q[$];
    logic [NCH-1:0] pend_ovf;

    serial_arith_nch_if #(.NCH(NCH)) bus ();

    serial_arith_nch #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check_output(input string name, input logic [NCH-1:0] got,
                                         input logic [NCH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endfunction

    // Monitor: one ovf expectation per cycle, one z expectation per valid bit.
    always @(negedge clk) begin
        zexp_t          e;
        logic [NCH-1:0] eo;
        if (ovf_q.size() > 0) begin
            eo = ovf_q.pop_front();
            check_output("ovf", bus.ovf, eo);
        end
        if (bus.z_valid === 1'b1) begin
            if (z_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL z_unexpected: got z_valid=1 want no valid bit at %0t", $time);
            end else begin
                e = z_q.pop_front();
                check_output("z", bus.z, e.z);
                check_output("z_last", {{(NCH-1){1'b0}}, bus.z_last}, {{(NCH-1){1'b0}}, e.last});
            end
        end else if (bus.z_valid === 1'b0) begin
            check_output("z_last_idle", {{(NCH-1){1'b0}}, bus.z_last}, '0);
        end
    end

    // One clock of stimulus; ovf seen next cycle is registered from this cycle.
    task automatic drive_cycle(input logic v, input logic [NCH-1:0] xv, input logic [1:0] m,
                               input logic s, input logic [NCH-1:0] ez, input logic el,
                               input logic [NCH-1:0] next_ovf);
        zexp_t e;
        bus.in_valid = v;
        bus.x        = xv;
        bus.mode     = m;
        bus.sclr     = s;
        ovf_q.push_back(pend_ovf);
        pend_ovf = next_ovf;
        if (v) begin
            e.z    = ez;
            e.last = el;
            z_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        areset       = 1'b1;
        bus.in_valid = 1'b0;
        bus.sclr     = 1'b0;
        bus.x        = '0;
        ovf_q.push_back('0);
        pend_ovf = '0;
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    // Feeds up to nbits of one word; optional idle gaps and a mid-word mode change.
    task automatic apply_stimulus(input logic [1:0] m, input logic [NCH-1:0][7:0] xin,
                                  input logic [NCH-1:0][7:0] zexp, input logic [NCH-1:0] eovf,
                                  input int nbits, input int gap_at0, input int gap_len0,
                                  input int gap_at1, input int gap_len1,
                                  input int toggle_at, input logic [1:0] toggle_mode);
        logic [NCH-1:0] xv;
        logic [NCH-1:0] ez;
        logic [1:0]     mv;
        for (int b = 0; b < nbits; b++) begin
            for (int l = 0; l < NCH; l++) begin
                xv[l] = xin[l][b];
                ez[l] = zexp[l][b];
            end
            mv = (toggle_at >= 0 && b >= toggle_at) ? toggle_mode : m;
            drive_cycle(1'b1, xv, mv, 1'b0, ez, (b == WIDTH - 1),
                        (b == WIDTH - 1) ? eovf : '0);
            if (b == gap_at0) begin
                for (int g = 0; g < gap_len0; g++)
                    drive_cycle(1'b0, NCH'($urandom), 2'd0, 1'b0, '0, 1'b0, '0);
            end
            if (b == gap_at1) begin
                for (int g = 0; g < gap_len1; g++)
                    drive_cycle(1'b0, NCH'($urandom), 2'd3, 1'b0, '0, 1'b0, '0);
            end
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        pend_ovf     = '0;
        areset       = 1'b1;
        bus.in_valid = 1'b0;
        bus.sclr     = 1'b0;
        bus.mode     = 2'd0;
        bus.x        = '0;
        @(posedge clk);
        #1;
        reset_cycle();
        reset_cycle();
        drive_cycle(1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0);

        // negate 06 -> FA
        apply_stimulus(2'd1, {8'h00, 8'h00, 8'h00, 8'h06}, {8'h00, 8'h00, 8'h00, 8'hFA},
                       4'b0000, 8, -1, 0, -1, 0, -1, 2'd0);
        drive_cycle(1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0);

        // negate 80 overflows, 00 and 01 do not
        apply_stimulus(2'd1, {8'h00, 8'h00, 8'h80, 8'h01}, {8'h00, 8'h00, 8'h80, 8'hFF},
                       4'b0010, 8, -1, 0, -1, 0, -1, 2'd0);
        drive_cycle(1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0);
        drive_cycle(1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0);

        // increment then decrement back to back
        apply_stimulus(2'd2, {8'h80, 8'h05, 8'hFF, 8'h7F}, {8'h81, 8'h06, 8'h00, 8'h80},
                       4'b0001, 8, -1, 0, -1, 0, -1, 2'd0);
        apply_stimulus(2'd3, {8'h10, 8'h01, 8'h80, 8'h00}, {8'h0F, 8'h00, 8'h7F, 8'hFF},
                       4'b0010, 8, -1, 0, -1, 0, -1, 2'd0);

        // decrement with mode input switched to pass at bit 3
        apply_stimulus(2'd3, {8'h55, 8'hFF, 8'h00, 8'h80}, {8'h54, 8'hFE, 8'hFF, 8'h7F},
                       4'b0001, 8, -1, 0, -1, 0, 3, 2'd0);
        drive_cycle(1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0);

        // negate 0C with valid gaps after bits 2 and 5
        apply_stimulus(2'd1, {8'h00, 8'h00, 8'h00, 8'h0C}, {8'h00, 8'h00, 8'h00, 8'hF4},
                       4'b0000, 8, 2, 3, 5, 1, -1, 2'd0);
        drive_cycle(1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0);

        // overflowing word immediately followed by areset drops the flag
        apply_stimulus(2'd1, {8'h00, 8'h00, 8'h00, 8'h80}, {8'h00, 8'h00, 8'h00, 8'h80},
                       4'b0001, 8, -1, 0, -1, 0, -1, 2'd0);
        reset_cycle();

        // areset after bit 4, then a full negate 01 on all lanes
        apply_stimulus(2'd1, {4{8'h06}}, {4{8'hFA}}, 4'b0000, 5, -1, 0, -1, 0, -1, 2'd0);
        reset_cycle();
        apply_stimulus(2'd1, {4{8'h01}}, {4{8'hFF}}, 4'b0000, 8, -1, 0, -1, 0, -1, 2'd0);
        drive_cycle(1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0);

        // sclr after bit 4 with a simultaneous valid bit, then negate 01
        apply_stimulus(2'd1, {4{8'h06}}, {4{8'hFA}}, 4'b0000, 5, -1, 0, -1, 0, -1, 2'd0);
        drive_cycle(1'b1, 4'hF, 2'd1, 1'b1, 4'h0, 1'b0, '0);
        apply_stimulus(2'd1, {4{8'h01}}, {4{8'hFF}}, 4'b0000, 8, -1, 0, -1, 0, -1, 2'd0);

        for (int i = 0; i < 3; i++)
            drive_cycle(1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        #1;

        checks++;
        if (z_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL z_drain: got %0d results outstanding want 0", z_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
